// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-product vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECTED = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  localparam int unsigned NICKEL  = 5;
  localparam int unsigned DIME    = 10;
  localparam int unsigned QUARTER = 25;
  localparam int unsigned DOLLAR  = 100;

  // Width of the zero-padded price list handed to price_of.
  localparam int unsigned LIST_MAX_W = 1024;

  // Returns the cw-bit price held in slice idx of a packed price list.
  function automatic int unsigned price_of(input logic [LIST_MAX_W-1:0] list,
                                           input int unsigned idx,
                                           input int unsigned cw);
    logic [LIST_MAX_W-1:0] shifted;
    int unsigned           mask;
    shifted = list >> (idx * cw);
    mask    = (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    return shifted[31:0] & mask;
  endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-product stock counter bank: bulk restock, single decrement by index,
// and a sold-out flag per product.
module vend_stock
  import vend_pkg::*;
#(
  parameter int NUM_PROD = 6,
  parameter int STOCK_W  = 3,
  parameter int ID_W     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                restock,
  input  logic                dec,
  input  logic [ID_W-1:0]     dec_idx,
  output logic [NUM_PROD-1:0] sold_out
);

  logic [STOCK_W-1:0] stock [NUM_PROD];

  // Stock counters: reset empties the machine, restock fills every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_PROD; k++) stock[k] <= '0;
    end else if (restock) begin
      for (int k = 0; k < NUM_PROD; k++) stock[k] <= '1;
    end else if (dec) begin
      for (int k = 0; k < NUM_PROD; k++) begin
        if ((ID_W'(k) == dec_idx) && (stock[k] != '0))
          stock[k] <= stock[k] - STOCK_W'(1);
      end
    end
  end

  // Sold-out vector decoded straight from the counters.
  always_comb begin
    for (int k = 0; k < NUM_PROD; k++) sold_out[k] = (stock[k] == '0);
  end

endmodule

// File: rtl/vend_ctrl.sv
// Multi-product vending controller: coin acceptance, credit balance,
// product selection, dispense strobe and greedy coin-by-coin change.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_PROD   = 6,
  parameter int CREDIT_W   = 10,
  parameter int MAX_CREDIT = 500,
  parameter int STOCK_W    = 3,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_LIST =
    {10'd100, 10'd75, 10'd50, 10'd35, 10'd25, 10'd10}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        dime,
  input  logic                        quarter,
  input  logic                        dollar,
  input  logic                        cancel,
  input  logic [NUM_PROD-1:0]         sel,
  input  logic                        restock,
  output logic                        vend_out,
  output logic [$clog2(NUM_PROD)-1:0] vend_id,
  output logic                        chg_nickel,
  output logic                        chg_dime,
  output logic                        chg_quarter,
  output logic                        coin_reject,
  output logic [CREDIT_W-1:0]         credit,
  output logic [NUM_PROD-1:0]         sel_led,
  output logic [NUM_PROD-1:0]         sold_out,
  output logic                        busy
);

  localparam int ID_W = $clog2(NUM_PROD);
  localparam logic [LIST_MAX_W-1:0] PRICE_PAD = LIST_MAX_W'(PRICE_LIST);

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_r, credit_nxt;
  logic [ID_W-1:0]     sel_idx, sel_idx_nxt, sel_dec_idx, eff_idx;
  logic                sel_vld, sel_vld_nxt;
  logic                coin_reject_r, coin_reject_nxt;
  logic                restock_go, dec_go;

  logic                coin_any, coin_multi, coin_window, coin_ok, sel_ok;
  int unsigned         coin_val, coin_sum;
  logic [CREDIT_W-1:0] credit_add, price_eff, price_cur, chg_val;

  // Coin arbitration, selection decode and price lookups.
  always_comb begin
    coin_any    = dime | quarter | dollar;
    coin_multi  = (dime & quarter) | (dime & dollar) | (quarter & dollar);
    coin_val    = dollar ? DOLLAR : (quarter ? QUARTER : (dime ? DIME : 0));
    coin_window = (state == ST_IDLE) || (state == ST_SELECTED);
    coin_sum    = 32'(credit_r) + coin_val;
    coin_ok     = coin_any && coin_window && (coin_sum <= $unsigned(MAX_CREDIT));
    coin_reject_nxt = coin_any && (!coin_ok || coin_multi);
    credit_add  = coin_ok ? CREDIT_W'(coin_sum) : credit_r;

    sel_dec_idx = '0;
    for (int k = 0; k < NUM_PROD; k++) if (sel[k]) sel_dec_idx = ID_W'(k);
    sel_ok  = $onehot(sel) && ((sel & sold_out) == '0);
    eff_idx = sel_ok ? sel_dec_idx : sel_idx;

    price_eff = CREDIT_W'(price_of(PRICE_PAD, 32'(eff_idx), CREDIT_W));
    price_cur = CREDIT_W'(price_of(PRICE_PAD, 32'(sel_idx), CREDIT_W));

    if (credit_r >= CREDIT_W'(QUARTER))   chg_val = CREDIT_W'(QUARTER);
    else if (credit_r >= CREDIT_W'(DIME)) chg_val = CREDIT_W'(DIME);
    else                                  chg_val = CREDIT_W'(NICKEL);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Credit, latched selection and coin-reject strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_r      <= '0;
      sel_idx       <= '0;
      sel_vld       <= 1'b0;
      coin_reject_r <= 1'b0;
    end else begin
      credit_r      <= credit_nxt;
      sel_idx       <= sel_idx_nxt;
      sel_vld       <= sel_vld_nxt;
      coin_reject_r <= coin_reject_nxt;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nxt   = state;
    credit_nxt  = credit_r;
    sel_idx_nxt = sel_idx;
    sel_vld_nxt = sel_vld;
    restock_go  = 1'b0;
    dec_go      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        credit_nxt = credit_add;
        restock_go = restock;
        if (cancel && (credit_add != '0)) begin
          state_nxt = ST_CHANGE;
        end else if (sel_ok) begin
          sel_idx_nxt = sel_dec_idx;
          sel_vld_nxt = 1'b1;
          // Enough credit already banked: skip straight to the dispense.
          state_nxt   = (credit_add >= price_eff) ? ST_DISPENSE : ST_SELECTED;
        end
      end
      ST_SELECTED: begin
        credit_nxt = credit_add;
        if (cancel) begin
          // Cancel beats a completing coin; the coin stays in the refund.
          sel_vld_nxt = 1'b0;
          state_nxt   = (credit_add != '0) ? ST_CHANGE : ST_IDLE;
        end else begin
          if (sel_ok) sel_idx_nxt = sel_dec_idx;
          if (credit_add >= price_eff) state_nxt = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        credit_nxt  = credit_r - price_cur;
        dec_go      = 1'b1;
        sel_vld_nxt = 1'b0;
        state_nxt   = (credit_r != price_cur) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        credit_nxt = (credit_r > chg_val) ? (credit_r - chg_val) : '0;
        state_nxt  = (credit_r > chg_val) ? ST_CHANGE : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    vend_out    = (state == ST_DISPENSE);
    vend_id     = vend_out ? sel_idx : '0;
    busy        = (state == ST_DISPENSE) || (state == ST_CHANGE);
    chg_quarter = (state == ST_CHANGE) && (chg_val == CREDIT_W'(QUARTER));
    chg_dime    = (state == ST_CHANGE) && (chg_val == CREDIT_W'(DIME));
    chg_nickel  = (state == ST_CHANGE) && (chg_val == CREDIT_W'(NICKEL));
    coin_reject = coin_reject_r;
    credit      = credit_r;
    for (int k = 0; k < NUM_PROD; k++) sel_led[k] = sel_vld && (ID_W'(k) == sel_idx);
  end

  vend_stock #(
    .NUM_PROD (NUM_PROD),
    .STOCK_W  (STOCK_W),
    .ID_W     (ID_W)
  ) u_stock (
    .clk      (clk),
    .rst_n    (rst_n),
    .restock  (restock_go),
    .dec      (dec_go),
    .dec_idx  (sel_idx),
    .sold_out (sold_out)
  );

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with hand-computed expectations.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, dime, quarter, dollar, cancel, restock;
  logic [5:0] sel;
  logic       vend_out, chg_nickel, chg_dime, chg_quarter, coin_reject, busy;
  logic [2:0] vend_id;
  logic [9:0] credit;
  logic [5:0] sel_led, sold_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vend_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dime        (dime),
    .quarter     (quarter),
    .dollar      (dollar),
    .cancel      (cancel),
    .sel         (sel),
    .restock     (restock),
    .vend_out    (vend_out),
    .vend_id     (vend_id),
    .chg_nickel  (chg_nickel),
    .chg_dime    (chg_dime),
    .chg_quarter (chg_quarter),
    .coin_reject (coin_reject),
    .credit      (credit),
    .sel_led     (sel_led),
    .sold_out    (sold_out),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic d, input logic q, input logic dl);
    dime = d; quarter = q; dollar = dl;
    cyc();
    dime = 0; quarter = 0; dollar = 0;
  endtask

  task automatic do_sel(input logic [5:0] s);
    sel = s;
    cyc();
    sel = '0;
  endtask

  task automatic do_cancel();
    cancel = 1;
    cyc();
    cancel = 0;
  endtask

  task automatic do_restock();
    restock = 1;
    cyc();
    restock = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nq, nother;
    rst_n = 0; dime = 0; quarter = 0; dollar = 0; cancel = 0; restock = 0; sel = '0;

    // Reset values
    #3;
    chk("rst_credit",   32'(credit),      0);
    chk("rst_sold_out", 32'(sold_out),    32'h3f);
    chk("rst_sel_led",  32'(sel_led),     0);
    chk("rst_vend",     32'(vend_out),    0);
    chk("rst_busy",     32'(busy),        0);
    chk("rst_reject",   32'(coin_reject), 0);
    chk("rst_vend_id",  32'(vend_id),     0);
    cyc(); cyc();
    rst_n = 1;
    cyc();

    // Sold-out product0 ignored before restock
    do_sel(6'b000001);
    chk("so_sel_led", 32'(sel_led),  0);
    chk("so_busy",    32'(busy),     0);
    chk("so_soldout", 32'(sold_out), 32'h3f);

    do_restock();
    chk("restock_soldout", 32'(sold_out), 0);
    chk("restock_stock1",  32'(dut.u_stock.stock[1]), 7);

    // Product1 (25c) with three dimes -> nickel change
    do_sel(6'b000010);
    chk("t1_sel_led", 32'(sel_led), 32'h02);
    coin(1, 0, 0);
    chk("t1_credit10", 32'(credit), 10);
    coin(1, 0, 0);
    chk("t1_credit20", 32'(credit), 20);
    chk("t1_novend",   32'(vend_out), 0);
    coin(1, 0, 0);
    chk("t1_vend",     32'(vend_out), 1);
    chk("t1_vend_id",  32'(vend_id),  1);
    chk("t1_credit30", 32'(credit),   30);
    chk("t1_busy",     32'(busy),     1);
    cyc();
    chk("t1_nickel",   32'(chg_nickel), 1);
    chk("t1_nodime",   32'(chg_dime),   0);
    chk("t1_credit5",  32'(credit),     5);
    chk("t1_vend_off", 32'(vend_out),   0);
    chk("t1_sel_clr",  32'(sel_led),    0);
    cyc();
    chk("t1_idle_busy",   32'(busy),       0);
    chk("t1_credit0",     32'(credit),     0);
    chk("t1_nickel_off",  32'(chg_nickel), 0);
    chk("t1_stock1",      32'(dut.u_stock.stock[1]), 6);

    // Dollar first, then product4 (75c) dispenses immediately
    coin(0, 0, 1);
    chk("t2_credit100", 32'(credit), 100);
    chk("t2_idle",      32'(busy),   0);
    do_sel(6'b010000);
    chk("t2_vend",      32'(vend_out), 1);
    chk("t2_vend_id",   32'(vend_id),  4);
    cyc();
    chk("t2_quarter",   32'(chg_quarter), 1);
    chk("t2_credit25",  32'(credit),      25);
    cyc();
    chk("t2_idle_end",  32'(busy),   0);
    chk("t2_credit0",   32'(credit), 0);

    // Product5 (100c), quarter, dime, cancel -> quarter then dime refund
    do_sel(6'b100000);
    chk("t3_sel_led", 32'(sel_led), 32'h20);
    coin(0, 1, 0);
    coin(1, 0, 0);
    chk("t3_credit35", 32'(credit), 35);
    do_cancel();
    chk("t3_busy",     32'(busy),        1);
    chk("t3_novend",   32'(vend_out),    0);
    chk("t3_quarter",  32'(chg_quarter), 1);
    cyc();
    chk("t3_dime",     32'(chg_dime),    1);
    chk("t3_novend2",  32'(vend_out),    0);
    chk("t3_credit10", 32'(credit),      10);
    cyc();
    chk("t3_idle",     32'(busy),   0);
    chk("t3_credit0",  32'(credit), 0);

    // Non-one-hot select ignored
    do_sel(6'b000011);
    chk("multi_sel_led", 32'(sel_led), 0);

    // Simultaneous dime+dollar: dollar taken, reject strobed one cycle
    coin(1, 0, 1);
    chk("cc_credit100", 32'(credit),      100);
    chk("cc_reject",    32'(coin_reject), 1);
    cyc();
    chk("cc_reject_off", 32'(coin_reject), 0);
    coin(0, 0, 1); coin(0, 0, 1); coin(0, 0, 1);
    coin(0, 1, 0); coin(0, 1, 0);
    chk("cc_credit450", 32'(credit), 450);
    chk("cc_no_reject", 32'(coin_reject), 0);
    coin(0, 0, 1);
    chk("cc_over_reject", 32'(coin_reject), 1);
    chk("cc_over_credit", 32'(credit),      450);

    // Refund 450 with a quarter inserted mid-change
    do_cancel();
    nq = 0; nother = 0;
    if (chg_quarter) nq++;
    coin(0, 1, 0);
    chk("chg_coin_reject", 32'(coin_reject), 1);
    chk("chg_credit425",   32'(credit),      425);
    for (int i = 0; i < 40 && busy; i++) begin
      if (chg_quarter) nq++;
      if (chg_dime || chg_nickel) nother++;
      cyc();
    end
    chk("chg_quarters", 32'(nq),     18);
    chk("chg_others",   32'(nother), 0);
    chk("chg_idle",     32'(busy),   0);
    chk("chg_credit0",  32'(credit), 0);

    // Drain product0: seven purchases at 10c
    for (int i = 0; i < 7; i++) begin
      do_sel(6'b000001);
      coin(1, 0, 0);
      chk("p0_vend", 32'(vend_out), 1);
      cyc();
    end
    chk("p0_soldout", 32'(sold_out[0]), 1);
    chk("p0_idle",    32'(busy),        0);
    do_sel(6'b000001);
    chk("p0_eighth_sel", 32'(sel_led), 0);
    coin(1, 0, 0);
    chk("p0_eighth_novend", 32'(vend_out), 0);
    chk("p0_credit10",      32'(credit),   10);
    do_cancel();
    chk("p0_refund_dime", 32'(chg_dime), 1);
    cyc();
    chk("p0_refund_done", 32'(busy), 0);

    // Reset in the middle of a refund
    coin(0, 0, 1);
    do_cancel();
    cyc();
    chk("mr_in_change", 32'(chg_quarter), 1);
    chk("mr_credit75",  32'(credit),      75);
    rst_n = 0;
    #1;
    chk("mr_quarter", 32'(chg_quarter), 0);
    chk("mr_dime",    32'(chg_dime),    0);
    chk("mr_nickel",  32'(chg_nickel),  0);
    chk("mr_busy",    32'(busy),        0);
    chk("mr_credit",  32'(credit),      0);
    chk("mr_soldout", 32'(sold_out),    32'h3f);
    cyc();
    rst_n = 1;
    cyc();
    chk("mr_post_busy",    32'(busy),        0);
    chk("mr_post_credit",  32'(credit),      0);
    chk("mr_post_quarter", 32'(chg_quarter), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised multi-product vending controller: the next-generation successor to the single-product vend FSM. It accepts coin pulses, holds a credit balance, and tracks per-product price and stock. It dispenses the selected product once credit covers the price, then returns change coin by coin. It sits between the coin/button front end and the dispense, LED and display drivers.

## Interface
Parameters:
- NUM_PROD, 6: number of products.
- CREDIT_W, 10: credit register width, in cents.
- MAX_CREDIT, 500: credit ceiling; a coin that would exceed it is rejected.
- STOCK_W, 3: per-product stock counter width. Restock fills to 2^STOCK_W-1.
- PRICE_LIST, {100,75,50,35,25,10}: packed NUM_PROD×CREDIT_W. Product k is in slice k (product0 = 10). All prices are multiples of 5, nonzero, and ≤ MAX_CREDIT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dime, quarter, dollar  in  1 each  synchronous one-cycle coin pulses.
- cancel  in  1  synchronous pulse: refund all credit.
- sel  in  NUM_PROD  one-hot product-select pulse.
- restock  in  1  pulse: fill all stock counters.
- vend_out  out  1  one-cycle dispense strobe.
- vend_id  out  $clog2(NUM_PROD)  index of the dispensed product; valid with vend_out.
- chg_nickel, chg_dime, chg_quarter  out  1 each  one-cycle change-coin strobes.
- coin_reject  out  1  one-cycle strobe for each sampled cycle in which a coin was refused.
- credit  out  CREDIT_W  current balance, for the display.
- sel_led  out  NUM_PROD  one-hot selected product; 0 when nothing is selected.
- sold_out  out  NUM_PROD  bit k = (stock[k] == 0).
- busy  out  1  high in DISPENSE or CHANGE.

## Operation
- States: IDLE, SELECTED, DISPENSE, CHANGE.
- Coins are accepted in IDLE and SELECTED.
  - If more than one coin pulses in the same cycle, only the highest value is taken (dollar > quarter > dime) and coin_reject=1.
  - If credit+coin would exceed MAX_CREDIT, that coin is dropped and coin_reject=1.
  - In DISPENSE or CHANGE, any coin is dropped and coin_reject=1.
- IDLE:
  - A one-hot sel with stock>0 latches the product index and moves to SELECTED.
  - A sel that is not one-hot, or that names a sold-out product, is ignored.
  - cancel with credit>0 moves to CHANGE; cancel with credit==0 is ignored.
  - restock is honoured only in IDLE and sets every stock counter to all-ones.
- SELECTED:
  - A valid new sel re-latches the product.
  - When the next-credit value is ≥ price, move to DISPENSE.
  - cancel moves to CHANGE and wins over a completing coin in the same cycle; no vend occurs.
- DISPENSE (exactly 1 cycle):
  - vend_out=1 and vend_id=latched index.
  - credit -= price, stock[id] -= 1, selection cleared.
  - Next state is CHANGE if the remaining credit > 0, else IDLE.
- CHANGE:
  - One strobe per cycle, largest coin first: quarter if credit≥25, else dime if credit≥10, else nickel.
  - credit is decremented by the coin value each cycle.
  - Leaving CHANGE for IDLE occurs in the cycle credit reaches 0.
  - cancel, sel and restock are ignored.
- Arithmetic is unsigned CREDIT_W. Credit never wraps, because additions are guarded by MAX_CREDIT and subtractions by the compare.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- A coin sampled at edge t updates credit at edge t.
  - If that coin completes the price, state=DISPENSE after edge t, so vend_out is high in the cycle t..t+1.
  - The first change strobe follows in the next cycle.
- Refund of credit C takes N cycles of CHANGE, where N is the greedy coin count; busy is high throughout.
- Reset (rst_n=0, immediate):
  - state=IDLE, credit=0, every stock counter=0 (sold_out all ones), sel_led=0.
  - vend_out, chg_*, coin_reject and busy are 0; vend_id=0.
- Reset mid-DISPENSE or mid-CHANGE abandons the operation; no further strobes are issued.

## Structure
- Package vend_pkg holds:
  - the state enum;
  - coin constants NICKEL=5, DIME=10, QUARTER=25, DOLLAR=100;
  - function price_of(idx) slicing PRICE_LIST.
- Sub-module vend_stock: the NUM_PROD stock-counter bank with restock, decrement-by-index and the sold_out vector.
- The FSM, credit path and change generator stay in vend_ctrl.

## Test plan
- Restock; sel product1 (25¢); three dime pulses. Required: vend_out in the cycle after the third dime with vend_id=1; credit 30→5; one chg_nickel; IDLE with credit=0; stock[1]=6.
- dollar in IDLE, then sel product4 (75¢). Required: DISPENSE in the cycle after sel; one chg_quarter; IDLE.
- sel product5 (100¢); quarter; dime; cancel. Required: chg_quarter then chg_dime; no vend_out; IDLE.
- After reset with no restock, sel product0. Required: stays IDLE, sel_led=0, sold_out=6'b111111. Then restock and buy product0 seven times. Required: sold_out[0]=1, and an eighth sel is ignored.
- Coin edge cases:
  - dime+dollar in the same cycle: credit +100, coin_reject=1.
  - Credit at 450, then a dollar: rejected, credit stays 450.
  - A quarter during CHANGE: coin_reject=1, refund unaffected.
- rst_n pulsed low mid-CHANGE. Required: all strobes 0 immediately, credit=0, stock all zero, IDLE after release.
